// File: rtl/cc_wrap_serializer.sv
// cc_wrap_serializer: pops cache lines from a show-ahead FIFO and emits them as R-channel bursts, critical-word-first wrapping when CC_SER_WRAP_EN is defined
module cc_wrap_serializer #(
  parameter int LINE_W = 512,
  parameter int BEAT_W = 64,
  parameter int OFS_W = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fifo_empty_i,
  input  logic [OFS_W+LINE_W-1:0] fifo_rdata_i,
  output logic                    fifo_rden_o,
  output logic [BEAT_W-1:0]       rdata_o,
  output logic                    rlast_o,
  output logic                    rvalid_o,
  input  logic                    rready_i
);
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int IDX_W = $clog2(BEATS);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [IDX_W-1:0] idx_q, idx_d, cnt_q, cnt_d, start;
  logic hs, last, load, unused_ofs;
  assign unused_ofs = ^fifo_rdata_i[LINE_W +: OFS_W];
`ifdef CC_SER_WRAP_EN
  localparam int BSH = $clog2(BEAT_W / 8);
  assign start = fifo_rdata_i[LINE_W+BSH +: IDX_W];
`else
  assign start = '0;
`endif
  assign rvalid_o = state_q == SEND;
  assign last = cnt_q == IDX_W'(BEATS - 1);
  assign hs = rvalid_o & rready_i;
  assign load = rst_n & ~fifo_empty_i & ((state_q == IDLE) | (hs & last));
  assign fifo_rden_o = load;
  assign rlast_o = rvalid_o & last;
  assign rdata_o = line_q[idx_q*BEAT_W +: BEAT_W];
  always_comb begin
    state_d = load ? SEND : (hs & last) ? IDLE : state_q;
    line_d = load ? fifo_rdata_i[LINE_W-1:0] : line_q;
    idx_d = load ? start : hs ? idx_q + 1'b1 : idx_q;
    cnt_d = load ? '0 : hs ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      line_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      line_q <= line_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
